// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow flop
// produce D = A - B LSB-first, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra, rb, res;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             accept, last_bit;
    logic             a_bit, b_bit, d_bit, nb;
    logic [WIDTH-1:0] d_msb, res_next;

    // A request is honoured only when no operation is in flight.
    assign accept   = start && (state_q == IDLE || state_q == DONE);
    assign last_bit = (state_q == SHIFT) && (cnt == LAST);
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_bit = ra[0];
        b_bit = rb[0];
        d_bit = a_bit ^ b_bit ^ brw;
        nb    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);
        // Insert the new difference bit at the MSB without slicing, so WIDTH=1 still elaborates.
        d_msb            = '0;
        d_msb[WIDTH-1]   = d_bit;
        res_next         = (res >> 1) | d_msb;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            res  <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            D    <= '0;
            Bout <= 1'b0;
        end else if (accept) begin
            ra  <= A;
            rb  <= B;
            brw <= 1'b0;
            cnt <= '0;
        end else if (state_q == SHIFT) begin
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            res <= res_next;
            brw <= nb;
            cnt <= cnt + CW'(1);
            // Results are published only as the last bit retires; they hold until the next one.
            if (last_bit) begin
                D    <= res_next;
                Bout <= nb;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8, 4 and 1: stimulus pushes
// {A<B, A-B} expectations, per-instance monitors pop and compare on done.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, busy, done, bout;
    logic [7:0] a, b, d;
    logic       start4, busy4, done4, bout4;
    logic [3:0] a4, b4, d4;
    logic       start1, busy1, done1, bout1;
    logic [0:0] a1, b1, d1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
        .busy(busy), .done(done), .D(d), .Bout(bout)
    );
    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .D(d4), .Bout(bout4)
    );
    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .D(d1), .Bout(bout1)
    );

    int errors = 0;
    int checks = 0;
    int q8[$], q4[$], q1[$];
    int dones8 = 0;
    int last_res8 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {borrow, difference} from plain unsigned arithmetic.
    function automatic int model(input int x, input int y, input int w);
        int diff;
        diff = (x - y) & ((1 << w) - 1);
        return ((x < y) ? (1 << w) : 0) | diff;
    endfunction

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: done with empty scoreboard (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            dones8++;
            if (q8.size() == 0) unexpected("w8_result");
            else begin
                last_res8 = q8.pop_front();
                check("w8_result", {23'd0, bout, d}, last_res8);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (q4.size() == 0) unexpected("w4_result");
            else check("w4_result", {27'd0, bout4, d4}, q4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) unexpected("w1_result");
            else check("w1_result", {30'd0, bout1, d1}, q1.pop_front());
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Issue one WIDTH=8 op from IDLE/DONE and check busy/done timing edge by edge.
    task automatic run_op(input int x, input int y);
        @(negedge clk);
        a = 8'(x);
        b = 8'(y);
        start = 1'b1;
        q8.push_back(model(x, y, 8));
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        check("busy_after_accept", busy, 1);
        check("no_done_after_accept", done, 0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i < 8) begin
                check("busy_in_shift", busy, 1);
                check("no_done_in_shift", done, 0);
                if (i == 4) check("hold_prev_result", {23'd0, bout, d}, last_res8);
            end else begin
                check("done_latency", done, 1);
                check("busy_low_in_done", busy, 0);
            end
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (!done) check("busy_during_b2b", busy, 1);
            else check("busy_low_at_b2b_done", busy, 0);
        end while (!done && cycles < 20);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL b2b_timeout: no done within %0d cycles", cycles);
        end
    endtask

    initial begin
        int cyc, n0, x, y;
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", {bout, d}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed operand pairs including wrap and equal-operand cases.
        run_op(100, 37);
        run_op(37, 100);
        run_op(0, 1);
        run_op(8'hA5, 8'hA5);
        run_op(255, 0);
        run_op(0, 255);

        // A second start while shifting must be dropped.
        @(negedge clk);
        a = 8'd200; b = 8'd55; start = 1'b1;
        q8.push_back(model(200, 55, 8));
        @(negedge clk);
        start = 1'b0;
        n0 = dones8;
        repeat (3) @(negedge clk);
        a = 8'd1; b = 8'd250; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("single_done_after_ignored_start", dones8 - n0, 1);

        // Back-to-back with start held high: one result every WIDTH+1 cycles.
        @(negedge clk);
        x = 77; y = 210;
        a = 8'(x); b = 8'(y); start = 1'b1;
        q8.push_back(model(x, y, 8));
        for (int k = 0; k < 6; k++) begin
            wait_done(cyc);
            check("b2b_period", cyc, 9);
            if (k < 5) begin
                x = $urandom_range(0, 255);
                y = $urandom_range(0, 255);
                a = 8'(x); b = 8'(y);
                q8.push_back(model(x, y, 8));
            end else begin
                start = 1'b0;
            end
        end
        run_op(180, 20);

        // Asynchronous reset four cycles into SHIFT aborts with no done.
        @(negedge clk);
        a = 8'd9; b = 8'd200; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n0 = dones8;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", busy, 0);
        check("midop_reset_done", done, 0);
        check("midop_reset_result", {bout, d}, 0);
        last_res8 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", dones8 - n0, 0);
        run_op(150, 151);
        run_op(151, 150);

        // Random sweep at WIDTH=8.
        for (int i = 0; i < 1000; i++) begin
            run_op($urandom_range(0, 255), $urandom_range(0, 255));
        end

        // Exhaustive WIDTH=4, streamed with start held high.
        @(negedge clk);
        a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
        q4.push_back(model(0, 0, 4));
        for (int i = 1; i <= 256; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done4 && cyc < 20);
            check("w4_period", cyc, 5);
            if (i < 256) begin
                a4 = 4'(i >> 4);
                b4 = 4'(i);
                q4.push_back(model(i >> 4, i & 15, 4));
            end else begin
                start4 = 1'b0;
            end
        end

        // Exhaustive WIDTH=1: a single SHIFT cycle per op.
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; start1 = 1'b1;
        q1.push_back(model(0, 0, 1));
        for (int i = 1; i <= 4; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done1 && cyc < 20);
            check("w1_period", cyc, 2);
            if (i < 4) begin
                a1 = 1'(i >> 1);
                b1 = 1'(i);
                q1.push_back(model(i >> 1, i & 1, 1));
            end else begin
                start1 = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        check("w8_scoreboard_drained", q8.size(), 0);
        check("w4_scoreboard_drained", q4.size(), 0);
        check("w1_scoreboard_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
